// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - valid/ready single-port memory responder with programmable wait states
// One request at a time: IDLE captures, WAIT counts down, RESP strobes ready_o and commits.
module mem_responder #(
  parameter int WIDTH       = 16,
  parameter int ADDR_WIDTH  = 4,
  parameter int WAIT_STATES = 1,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic                  wr_rd_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [WIDTH-1:0]      wr_data_i,
  output logic [WIDTH-1:0]      rd_data_o,
  output logic                  ready_o,
  output logic [CNT_WIDTH-1:0]  wr_cnt_o,
  output logic [CNT_WIDTH-1:0]  rd_cnt_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_wait_cnt;
  logic [3:0]            w_wait_cnt_nxt;
  logic                  r_wr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WIDTH-1:0]      r_wdata;
  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [WIDTH-1:0]      r_rd_data;
  logic [CNT_WIDTH-1:0]  r_wr_cnt;
  logic [CNT_WIDTH-1:0]  r_rd_cnt;
  logic                  w_capture;
  logic                  w_commit;
  logic                  w_load_rd;
  logic [ADDR_WIDTH-1:0] w_rd_addr;

  always_comb begin
    w_next         = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_capture      = 1'b0;
    w_commit       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (valid_i) begin
          w_capture      = 1'b1;
          w_wait_cnt_nxt = 4'(WAIT_STATES);
          w_next         = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        // A dropped valid abandons the request before anything becomes visible.
        if (!valid_i) begin
          w_next = S_IDLE;
        end else if (r_wait_cnt == 4'd1) begin
          w_next = S_RESP;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt - 4'd1;
        end
      end
      S_RESP: begin
        w_next   = S_IDLE;
        w_commit = valid_i;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // With zero wait states RESP follows IDLE directly, so the live request is used.
  always_comb begin
    w_rd_addr = w_capture ? addr_i : r_addr;
    w_load_rd = (w_next == S_RESP) && (w_capture ? !wr_rd_i : !r_wr);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
      r_wr       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rd_data  <= '0;
      r_wr_cnt   <= '0;
      r_rd_cnt   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_capture) begin
        r_wr    <= wr_rd_i;
        r_addr  <= addr_i;
        r_wdata <= wr_data_i;
      end
      if (w_load_rd) begin
        r_rd_data <= r_mem[w_rd_addr];
      end
      if (w_commit) begin
        if (r_wr) begin
          r_mem[r_addr] <= r_wdata;
          r_wr_cnt      <= r_wr_cnt + CNT_WIDTH'(1);
        end else begin
          r_rd_cnt      <= r_rd_cnt + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign ready_o   = (r_state == S_RESP);
  assign rd_data_o = r_rd_data;
  assign wr_cnt_o  = r_wr_cnt;
  assign rd_cnt_o  = r_rd_cnt;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed bench for mem_responder
// Instance k runs with WAIT_STATES = k so each wait-state scenario has its own responder.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst   [4];
  logic        v     [4];
  logic        wrr   [4];
  logic [3:0]  a     [4];
  logic [15:0] wd    [4];
  logic [15:0] rd    [4];
  logic        rdy   [4];
  logic [7:0]  wc    [4];
  logic [7:0]  rc    [4];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar k = 0; k < 4; k++) begin : g_dut
    mem_responder #(
      .WIDTH(16), .ADDR_WIDTH(4), .WAIT_STATES(k), .CNT_WIDTH(8)
    ) u_dut (
      .clk_i(clk), .rst_i(rst[k]), .valid_i(v[k]), .wr_rd_i(wrr[k]),
      .addr_i(a[k]), .wr_data_i(wd[k]), .rd_data_o(rd[k]), .ready_o(rdy[k]),
      .wr_cnt_o(wc[k]), .rd_cnt_o(rc[k])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Holds valid until ready_o, then keeps it high across the RESP-exit edge.
  task automatic xfer(input int k, input logic wr, input logic [3:0] ad, input logic [15:0] d,
                      output logic [15:0] rdat, output int lat, output int rcyc);
    int  n;
    bit  seen;
    @(negedge clk);
    v[k] = 1'b1; wrr[k] = wr; a[k] = ad; wd[k] = d;
    n = 0; seen = 1'b0;
    while (!seen && n < 50) begin
      @(posedge clk); #1;
      n++;
      if (rdy[k]) seen = 1'b1;
    end
    if (!seen) chk("ready_timeout", 32'd0, 32'd1);
    rdat = rd[k]; lat = n; rcyc = cyc;
    @(posedge clk); #1;
    v[k] = 1'b0;
  endtask

  task automatic pulse_reset(input int k);
    @(negedge clk);
    rst[k] = 1'b0;
    @(negedge clk);
    rst[k] = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rdat;
    int          lat;
    int          rcyc;
    int          prev;
    bit          seen;
    for (int k = 0; k < 4; k++) begin
      rst[k] = 1'b0; v[k] = 1'b0; wrr[k] = 1'b0; a[k] = '0; wd[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) rst[k] = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_ready%0d", k), 32'(rdy[k]), 32'd0);
      chk($sformatf("rst_rdata%0d", k), 32'(rd[k]),  32'd0);
      chk($sformatf("rst_wcnt%0d", k),  32'(wc[k]),  32'd0);
      chk($sformatf("rst_rcnt%0d", k),  32'(rc[k]),  32'd0);
    end

    // W=1: write then read back, ready two cycles after valid
    xfer(1, 1'b1, 4'd3, 16'hABCD, rdat, lat, rcyc);
    chk("t1_wr_lat", 32'(lat), 32'd2);
    xfer(1, 1'b0, 4'd3, 16'h0000, rdat, lat, rcyc);
    chk("t1_rd_lat", 32'(lat), 32'd2);
    chk("t1_rdata", 32'(rdat), 32'hABCD);
    chk("t1_wcnt", 32'(wc[1]), 32'd1);
    chk("t1_rcnt", 32'(rc[1]), 32'd1);

    // W=0: back-to-back sweep, ready every second cycle
    prev = -1;
    for (int i = 0; i < 32; i++) begin
      xfer(0, (i < 16), 4'(i), 16'(i * 16'h11), rdat, lat, rcyc);
      chk($sformatf("t2_lat%0d", i), 32'(lat), 32'd1);
      if (prev >= 0) chk($sformatf("t2_period%0d", i), 32'(rcyc - prev), 32'd2);
      if (i >= 16) chk($sformatf("t2_rdata%0d", i - 16), 32'(rdat), 32'((i - 16) * 16'h11));
      prev = rcyc;
    end
    chk("t2_wcnt", 32'(wc[0]), 32'd16);
    chk("t2_rcnt", 32'(rc[0]), 32'd16);

    // W=3: valid dropped after two cycles in flight
    @(negedge clk);
    v[3] = 1'b1; wrr[3] = 1'b1; a[3] = 4'd7; wd[3] = 16'h5555;
    seen = 1'b0;
    repeat (2) begin @(posedge clk); #1; seen |= rdy[3]; end
    v[3] = 1'b0;
    repeat (4) begin @(posedge clk); #1; seen |= rdy[3]; end
    chk("t3_no_ready", 32'(seen), 32'd0);
    chk("t3_wcnt", 32'(wc[3]), 32'd0);
    xfer(3, 1'b0, 4'd7, 16'h0000, rdat, lat, rcyc);
    chk("t3_rd_lat", 32'(lat), 32'd4);
    chk("t3_rdata", 32'(rdat), 32'h0000);
    chk("t3_wcnt_after", 32'(wc[3]), 32'd0);
    chk("t3_rcnt_after", 32'(rc[3]), 32'd1);

    // W=2: reset during WAIT clears memory and counters
    xfer(2, 1'b1, 4'd1, 16'h1111, rdat, lat, rcyc);
    chk("t4_wr_lat", 32'(lat), 32'd3);
    chk("t4_wcnt_pre", 32'(wc[2]), 32'd1);
    @(negedge clk);
    v[2] = 1'b1; wrr[2] = 1'b1; a[2] = 4'd1; wd[2] = 16'h2222;
    @(posedge clk); #3;
    rst[2] = 1'b0;
    #1;
    chk("t4_rst_ready", 32'(rdy[2]), 32'd0);
    chk("t4_rst_wcnt", 32'(wc[2]), 32'd0);
    chk("t4_rst_rcnt", 32'(rc[2]), 32'd0);
    v[2] = 1'b0;
    @(negedge clk);
    rst[2] = 1'b1;
    xfer(2, 1'b0, 4'd1, 16'h0000, rdat, lat, rcyc);
    chk("t4_rdata", 32'(rdat), 32'h0000);
    chk("t4_wcnt_after", 32'(wc[2]), 32'd0);
    chk("t4_rcnt_after", 32'(rc[2]), 32'd1);

    // W=0: read counter wraps at 256
    pulse_reset(0);
    for (int i = 0; i < 256; i++) begin
      xfer(0, 1'b0, 4'(i), 16'h0000, rdat, lat, rcyc);
      if (i == 254) chk("t5_rcnt_255", 32'(rc[0]), 32'd255);
    end
    chk("t5_rcnt_wrap", 32'(rc[0]), 32'd0);
    chk("t5_wcnt", 32'(wc[0]), 32'd0);

    // W=1: a write leaves rd_data_o untouched
    xfer(1, 1'b1, 4'd5, 16'h1234, rdat, lat, rcyc);
    xfer(1, 1'b0, 4'd5, 16'h0000, rdat, lat, rcyc);
    chk("t6_rdata", 32'(rdat), 32'h1234);
    xfer(1, 1'b1, 4'd6, 16'hFFFF, rdat, lat, rcyc);
    chk("t6_hold_resp", 32'(rdat), 32'h1234);
    chk("t6_hold_after", 32'(rd[1]), 32'h1234);
    xfer(1, 1'b0, 4'd6, 16'h0000, rdat, lat, rcyc);
    chk("t6_rdata6", 32'(rdat), 32'hFFFF);
    chk("t6_wcnt", 32'(wc[1]), 32'd3);
    chk("t6_rcnt", 32'(rc[1]), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
